aud_dac_feeder: RTL and testbench
=================================

Name: aud_dac_feeder

Overview:
- Stereo sample buffer directly upstream of the I2S DAC serializer (AudPlayer).
- Accepts L/R sample pairs from the effector/FFT pipeline over a valid/ready handshake.
- Presents one pair per LRCK frame on o_dac_l/o_dac_r, which drive the serializer's i_dac_l/i_dac_r.
- Each pair is held stable for the whole frame.
- Absorbs upstream burstiness and flags underflow.

Parameters:
- DATA_W, 16: sample width per channel, two's complement.
- DEPTH, 8: FIFO depth in stereo pairs; power of 2, at least 2.
- PRIME_LVL, 4: FIFO level required before the first pop after enable; must be in 1..DEPTH.

Ports:
- i_bclk  in  1  audio bit clock; the only clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_en  in  1  enable; 0 flushes and mutes.
- i_daclrck  in  1  DAC LRCK, synchronous to i_bclk; 0 = left phase, 1 = right phase.
- i_valid  in  1  upstream pair valid.
- i_sample_l  in  DATA_W  upstream left sample.
- i_sample_r  in  DATA_W  upstream right sample.
- o_ready  out  1  FIFO can accept a pair.
- o_dac_l  out  DATA_W  left sample to the serializer.
- o_dac_r  out  DATA_W  right sample to the serializer.
- o_frame_req  out  1  one-cycle pulse at each frame start while enabled.
- o_level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- o_underflow  out  1  sticky; set when a frame starts with an empty FIFO in RUN.
- i_clr_uf  in  1  synchronous clear of o_underflow.

Behaviour:
- Reset values: o_dac_l/o_dac_r=0, o_ready=0, o_frame_req=0, o_level=0, o_underflow=0, lrck_q=1, state=IDLE, FIFO pointers=0.
- Frame start: lrck_q holds i_daclrck registered. fall = lrck_q & ~i_daclrck, evaluated combinationally at each rising i_bclk.
  - Outputs load on the same edge where fall is true.
  - Valid from the first bclk of the left phase; stable for 40+ bclk until the next fall.
  - The serializer samples no earlier than its one-bit I2S delay.
- Push: i_valid & o_ready at a rising edge writes {l,r}. o_ready = ~full & (state!=IDLE), derived from registered pointers.
- States:
  - IDLE (i_en=0): FIFO flushed every cycle, outputs 0, no pulses. i_en=1 moves to PRIME.
  - PRIME: pushes allowed. o_frame_req pulses on fall. Outputs stay 0; no pops, no underflow. On a fall with o_level>=PRIME_LVL, pop and load, then go to RUN.
  - RUN: every fall pops one pair into o_dac_l/o_dac_r. If the FIFO is empty, set o_underflow and apply the underflow output policy (Optional Feature); remain in RUN.
  - Any state with i_en=0: go to IDLE next edge; outputs 0 next edge.
- Simultaneous push and pop on a non-empty FIFO: both occur; level unchanged.
- Push into an empty FIFO on a fall edge: no bypass; it counts as underflow and the pushed pair is popped at the next fall.
- When full, o_ready=0. A pop in the same cycle does not raise o_ready until the next cycle.
- Pointer arithmetic wraps mod DEPTH. o_level = wr_cnt - rd_cnt on $clog2(DEPTH)+1 bits.
- o_underflow: set dominates i_clr_uf when both occur in the same cycle. Unaffected by i_en; cleared only by reset or i_clr_uf.
- Asynchronous reset mid-frame: all state returns to reset values immediately. The first fall after release is handled normally (lrck_q=1 makes an immediate low LRCK count as a fall).

Optional Feature:
- Macro: AUD_FEEDER_MUTE_ON_UNDERFLOW_EN.
- Defined: on an underflowed frame, o_dac_l/o_dac_r load 0.
- Undefined: on an underflowed frame, o_dac_l/o_dac_r hold the last popped pair (sample-and-hold).
- o_underflow behaviour is identical in both builds.

Decomposition:
- Shared package aud_pkg:
  - AUD_DATA_W=16.
  - typedef struct packed {logic signed [AUD_DATA_W-1:0] l, r;} aud_stereo_t.
  - typedef enum logic [1:0] {FD_IDLE, FD_PRIME, FD_RUN} feeder_state_t.
- Sub-module aud_stereo_fifo: synchronous FIFO of aud_stereo_t with push/pop/full/empty/level and a synchronous flush. The FSM, edge detect and output registers stay in aud_dac_feeder.

Test Plan:
- Reset and enable priming:
  - Stimulus: reset, LRCK 20 low/20 high. Enable, then push 3 pairs.
  - Response: outputs stay 0 across 2 frames. o_frame_req pulses once per fall. o_underflow=0.
  - Stimulus: push a 4th pair.
  - Response: the next fall loads the first pair (L=16'hFFFF, R=16'h0000), state RUN.
- Steady stream:
  - Stimulus: push (16'hEDB7,16'h1248), (16'hC936,16'h36C9), (16'h8124,16'h7EDB), one per frame.
  - Response: each pair appears on the fall edge in order. Outputs stable for all 40 bclk of the frame. o_level constant.
- Full back-pressure:
  - Stimulus: push 8 pairs during PRIME with LRCK frozen high.
  - Response: o_ready=0 after the 8th, and a 9th i_valid is not written. o_level=8. The next fall pops one, o_level=7, o_ready=1 one cycle later.
- Underflow:
  - Stimulus: in RUN, stop pushing until empty; one more fall.
  - Response: o_underflow=1. Outputs hold the last pair, or go to 0 in the MUTE build. i_clr_uf clears it. A coincident set and clear leaves it 1.
- Disable and reset mid-frame:
  - Stimulus: i_en=0 with 5 pairs queued.
  - Response: next cycle o_level=0, outputs 0, o_ready=0, no frame pulses.
  - Stimulus: assert i_rst_n low mid-left-phase.
  - Response: all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/aud_pkg.sv
// aud_pkg: shared audio types for the DAC feeder and its stereo FIFO.
package aud_pkg;
    localparam int AUD_DATA_W = 16;
    typedef struct packed {
        logic signed [AUD_DATA_W-1:0] l;
        logic signed [AUD_DATA_W-1:0] r;
    } aud_stereo_t;
    typedef enum logic [1:0] {FD_IDLE, FD_PRIME, FD_RUN} feeder_state_t;
endpackage

// File: rtl/aud_stereo_fifo.sv
// aud_stereo_fifo: synchronous FIFO of stereo pairs with flush; level = wr_cnt - rd_cnt.
module aud_stereo_fifo import aud_pkg::*; #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  aud_stereo_t              din,
    output aud_stereo_t              dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    aud_stereo_t mem [DEPTH];
    logic [AW:0] wr_cnt, rd_cnt;
    assign level = wr_cnt - rd_cnt;
    assign full  = level[AW];
    assign empty = level == '0;
    assign dout  = mem[rd_cnt[AW-1:0]];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else if (flush) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (push && !full) wr_cnt <= wr_cnt + 1'b1;
            if (pop && !empty) rd_cnt <= rd_cnt + 1'b1;
        end
    always_ff @(posedge clk)
        if (push && !full && !flush) mem[wr_cnt[AW-1:0]] <= din;
endmodule

// File: rtl/aud_dac_feeder.sv
// aud_dac_feeder: buffers L/R pairs and presents one per LRCK frame to the I2S serializer.
// Build option AUD_FEEDER_MUTE_ON_UNDERFLOW_EN: underflowed frames output 0 instead of holding.
module aud_dac_feeder #(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 8,
    parameter int PRIME_LVL = 4
) (
    input  logic                   i_bclk,
    input  logic                   i_rst_n,
    input  logic                   i_en,
    input  logic                   i_daclrck,
    input  logic                   i_valid,
    input  logic [DATA_W-1:0]      i_sample_l,
    input  logic [DATA_W-1:0]      i_sample_r,
    output logic                   o_ready,
    output logic [DATA_W-1:0]      o_dac_l,
    output logic [DATA_W-1:0]      o_dac_r,
    output logic                   o_frame_req,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_underflow,
    input  logic                   i_clr_uf
);
    import aud_pkg::*;
    localparam int LW = $clog2(DEPTH) + 1;
    feeder_state_t state;
    aud_stereo_t   head, din;
    logic lrck_q, full, empty, fall, push, pop, flush, uf_set;
    assign fall    = lrck_q & ~i_daclrck;
    assign o_ready = ~full & (state != FD_IDLE);
    assign push    = i_valid & o_ready;
    // Disabling flushes on the same edge so the level reads 0 one cycle later.
    assign flush   = ~i_en | (state == FD_IDLE);
    assign pop     = i_en & fall & ((state == FD_RUN) ? ~empty
                                    : (state == FD_PRIME) && (o_level >= LW'(PRIME_LVL)));
    assign uf_set  = i_en & fall & (state == FD_RUN) & empty;
    assign din     = {AUD_DATA_W'(i_sample_l), AUD_DATA_W'(i_sample_r)};
    aud_stereo_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (i_bclk),
        .rst_n (i_rst_n),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (o_level)
    );
    always_ff @(posedge i_bclk or negedge i_rst_n)
        if (!i_rst_n) begin
            state       <= FD_IDLE;
            lrck_q      <= 1'b1;
            o_dac_l     <= '0;
            o_dac_r     <= '0;
            o_frame_req <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            lrck_q      <= i_daclrck;
            o_underflow <= uf_set | (o_underflow & ~i_clr_uf);
            o_frame_req <= i_en & fall & (state != FD_IDLE);
            if (!i_en || state == FD_IDLE) begin
                state   <= i_en ? FD_PRIME : FD_IDLE;
                o_dac_l <= '0;
                o_dac_r <= '0;
            end else if (pop) begin
                state   <= FD_RUN;
                o_dac_l <= DATA_W'(head.l);
                o_dac_r <= DATA_W'(head.r);
            end
`ifdef AUD_FEEDER_MUTE_ON_UNDERFLOW_EN
            else if (uf_set) begin
                o_dac_l <= '0;
                o_dac_r <= '0;
            end
`endif
        end
endmodule

// File: tb/tb_aud_dac_feeder.sv
// tb_aud_dac_feeder: directed vector table plus randomized traffic checked against a queue model.
module tb_aud_dac_feeder;
    localparam int DEPTH = 8;
    localparam int PRIME_LVL = 4;
`ifdef AUD_FEEDER_MUTE_ON_UNDERFLOW_EN
    localparam bit MUTE = 1'b1;
`else
    localparam bit MUTE = 1'b0;
`endif
    logic i_bclk = 1'b0, i_rst_n, i_en, i_daclrck, i_valid, i_clr_uf;
    logic [15:0] i_sample_l, i_sample_r, o_dac_l, o_dac_r;
    logic o_ready, o_frame_req, o_underflow;
    logic [3:0] o_level;
    int n_tests = 0, n_fail = 0;

    aud_dac_feeder #(.DATA_W(16), .DEPTH(DEPTH), .PRIME_LVL(PRIME_LVL)) dut (
        .i_bclk(i_bclk), .i_rst_n(i_rst_n), .i_en(i_en), .i_daclrck(i_daclrck),
        .i_valid(i_valid), .i_sample_l(i_sample_l), .i_sample_r(i_sample_r),
        .o_ready(o_ready), .o_dac_l(o_dac_l), .o_dac_r(o_dac_r),
        .o_frame_req(o_frame_req), .o_level(o_level), .o_underflow(o_underflow),
        .i_clr_uf(i_clr_uf)
    );
    always #5 i_bclk = ~i_bclk;

    // Reference model: a queue of pairs plus enabled/running flags.
    logic [31:0] q[$];
    bit m_active, m_run, m_fr, m_uf, m_lrck;
    logic [15:0] m_l, m_r;

    task automatic model_reset();
        q.delete();
        m_active = 0; m_run = 0; m_fr = 0; m_uf = 0; m_lrck = 1; m_l = 0; m_r = 0;
    endtask

    task automatic model_edge();
        bit fall;
        int n;
        bit accept;
        fall = m_lrck & ~i_daclrck;
        n = q.size();
        accept = i_valid && m_active && n < DEPTH;
        m_uf = (i_en && m_active && m_run && fall && n == 0) ? 1'b1 : (i_clr_uf ? 1'b0 : m_uf);
        m_fr = 0;
        if (!i_en) begin
            q.delete(); m_l = 0; m_r = 0; m_active = 0; m_run = 0;
        end else if (!m_active) begin
            q.delete(); m_l = 0; m_r = 0; m_active = 1;
        end else begin
            m_fr = fall;
            if (fall && (m_run ? n > 0 : n >= PRIME_LVL)) begin
                {m_l, m_r} = q.pop_front();
                m_run = 1;
            end else if (fall && m_run && MUTE) begin
                m_l = 0; m_r = 0;
            end
            if (accept) q.push_back({i_sample_l, i_sample_r});
        end
        m_lrck = i_daclrck;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_bclk);
        if (i_rst_n) model_edge();
        #1;
        chk("dac_l", o_dac_l, m_l);
        chk("dac_r", o_dac_r, m_r);
        chk("level", o_level, q.size());
        chk("frame_req", o_frame_req, m_fr);
        chk("underflow", o_underflow, m_uf);
        chk("ready", o_ready, m_active && q.size() < DEPTH);
    endtask

    typedef struct {
        bit en, lr, v, clr;
        logic [15:0] l, r;
        int lvl;
        logic [15:0] el, er;
        bit fr, uf, rdy;
    } vec_t;
    vec_t tv[$];

    task automatic add(input bit en, lr, v, clr, input logic [15:0] l, r, input int lvl,
                       input logic [15:0] el, er, input bit fr, uf, rdy);
        vec_t t;
        t.en = en; t.lr = lr; t.v = v; t.clr = clr; t.l = l; t.r = r; t.lvl = lvl;
        t.el = el; t.er = er; t.fr = fr; t.uf = uf; t.rdy = rdy;
        tv.push_back(t);
    endtask

    initial begin
        logic [15:0] h5l, h5r, h6l, h6r;
        int mode;
        h5l = MUTE ? 16'h0 : 16'h5555; h5r = MUTE ? 16'h0 : 16'hAAAA;
        h6l = MUTE ? 16'h0 : 16'h6666; h6r = MUTE ? 16'h0 : 16'h9999;
        // priming, first pop, steady stream, drain to underflow, clear vs set
        add(1,1,0,0, 16'h0,    16'h0,    0, 0, 0, 0,0,1);
        add(1,1,1,0, 16'hFFFF, 16'h0000, 1, 0, 0, 0,0,1);
        add(1,0,1,0, 16'h1111, 16'hEEEE, 2, 0, 0, 1,0,1);
        add(1,0,1,0, 16'h2222, 16'hDDDD, 3, 0, 0, 0,0,1);
        add(1,1,1,0, 16'h3333, 16'hCCCC, 4, 0, 0, 0,0,1);
        add(1,0,0,0, 16'h0,    16'h0,    3, 16'hFFFF, 16'h0000, 1,0,1);
        add(1,0,1,0, 16'h4444, 16'hBBBB, 4, 16'hFFFF, 16'h0000, 0,0,1);
        add(1,1,0,0, 16'h0,    16'h0,    4, 16'hFFFF, 16'h0000, 0,0,1);
        add(1,0,1,0, 16'h5555, 16'hAAAA, 4, 16'h1111, 16'hEEEE, 1,0,1);
        add(1,1,0,0, 16'h0,    16'h0,    4, 16'h1111, 16'hEEEE, 0,0,1);
        add(1,0,0,0, 16'h0,    16'h0,    3, 16'h2222, 16'hDDDD, 1,0,1);
        add(1,1,0,0, 16'h0,    16'h0,    3, 16'h2222, 16'hDDDD, 0,0,1);
        add(1,0,0,0, 16'h0,    16'h0,    2, 16'h3333, 16'hCCCC, 1,0,1);
        add(1,1,0,0, 16'h0,    16'h0,    2, 16'h3333, 16'hCCCC, 0,0,1);
        add(1,0,0,0, 16'h0,    16'h0,    1, 16'h4444, 16'hBBBB, 1,0,1);
        add(1,1,0,0, 16'h0,    16'h0,    1, 16'h4444, 16'hBBBB, 0,0,1);
        add(1,0,0,0, 16'h0,    16'h0,    0, 16'h5555, 16'hAAAA, 1,0,1);
        add(1,1,0,0, 16'h0,    16'h0,    0, 16'h5555, 16'hAAAA, 0,0,1);
        add(1,0,1,0, 16'h6666, 16'h9999, 1, h5l, h5r, 1,1,1);
        add(1,1,0,1, 16'h0,    16'h0,    1, h5l, h5r, 0,0,1);
        add(1,0,0,0, 16'h0,    16'h0,    0, 16'h6666, 16'h9999, 1,0,1);
        add(1,1,0,0, 16'h0,    16'h0,    0, 16'h6666, 16'h9999, 0,0,1);
        add(1,0,0,1, 16'h0,    16'h0,    0, h6l, h6r, 1,1,1);
        add(1,1,0,1, 16'h0,    16'h0,    0, h6l, h6r, 0,0,1);
        // disable, re-prime to full with LRCK frozen high, then disable with pairs queued
        add(0,1,0,0, 16'h0,    16'h0,    0, 0, 0, 0,0,0);
        add(1,1,0,0, 16'h0,    16'h0,    0, 0, 0, 0,0,1);
        for (int k = 0; k < 8; k++)
            add(1,1,1,0, 16'hA000 + 16'(k), 16'h5000 + 16'(k), k + 1, 0, 0, 0,0, k < 7);
        add(1,1,1,0, 16'h9999, 16'h9999, 8, 0, 0, 0,0,0);
        add(1,0,0,0, 16'h0,    16'h0,    7, 16'hA000, 16'h5000, 1,0,1);
        add(0,0,0,0, 16'h0,    16'h0,    0, 0, 0, 0,0,0);
        add(0,1,0,0, 16'h0,    16'h0,    0, 0, 0, 0,0,0);
        add(0,0,0,0, 16'h0,    16'h0,    0, 0, 0, 0,0,0);

        i_rst_n = 0; i_en = 0; i_daclrck = 1; i_valid = 0; i_clr_uf = 0;
        i_sample_l = 0; i_sample_r = 0;
        model_reset();
        repeat (3) tick();
        i_rst_n = 1;

        for (int k = 0; k < tv.size(); k++) begin
            i_en = tv[k].en; i_daclrck = tv[k].lr; i_valid = tv[k].v; i_clr_uf = tv[k].clr;
            i_sample_l = tv[k].l; i_sample_r = tv[k].r;
            tick();
            chk("tv_level", o_level, tv[k].lvl);
            chk("tv_dac_l", o_dac_l, tv[k].el);
            chk("tv_dac_r", o_dac_r, tv[k].er);
            chk("tv_frame_req", o_frame_req, tv[k].fr);
            chk("tv_underflow", o_underflow, tv[k].uf);
            chk("tv_ready", o_ready, tv[k].rdy);
        end

        // randomized traffic with 40-bclk frames, bursts, rare disables and clears
        mode = 0;
        for (int i = 0; i < 6000; i++) begin
            if (i % 200 == 0) mode = $urandom_range(0, 3);
            i_daclrck  = (i % 40) >= 20;
            i_en       = !((i % 1000) >= 500 && (i % 1000) < 506);
            i_valid    = mode == 0 ? $urandom_range(0, 9) != 0 :
                         mode == 1 ? $urandom_range(0, 39) == 0 :
                         mode == 3 ? $urandom_range(0, 1) == 1 : 1'b0;
            i_clr_uf   = $urandom_range(0, 99) == 0;
            i_sample_l = 16'($urandom);
            i_sample_r = 16'($urandom);
            tick();
        end

        // asynchronous reset in the middle of a left phase
        i_en = 1; i_valid = 1; i_clr_uf = 0; i_daclrck = 1;
        repeat (20) tick();
        i_daclrck = 0;
        repeat (5) tick();
        #2 i_rst_n = 0;
        #1;
        chk("rst_dac_l", o_dac_l, 0);
        chk("rst_dac_r", o_dac_r, 0);
        chk("rst_level", o_level, 0);
        chk("rst_ready", o_ready, 0);
        chk("rst_underflow", o_underflow, 0);
        chk("rst_frame_req", o_frame_req, 0);
        model_reset();
        repeat (2) tick();
        i_rst_n = 1;
        for (int i = 0; i < 400; i++) begin
            i_daclrck  = (i % 40) >= 20;
            i_valid    = $urandom_range(0, 3) != 0;
            i_sample_l = 16'($urandom);
            i_sample_r = 16'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
